// File: rtl/prog_loader.sv
// Boot-time program loader: packs a length-prefixed byte stream into 32-bit words,
// writes them to instruction memory and then releases the processor from reset.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DRAIN,
        S_DONE,
        S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t DATA_EXIT = S_CSUM;
`else
    localparam state_t DATA_EXIT = S_DRAIN;
`endif

    // Largest legal word count; one bit wider than the length field so 2**16 fits.
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         word_buf_q, word_buf_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept;
    logic [2:0]          lane_sel;

    assign accept = in_valid & in_ready_q;

    // One-hot select of the byte lane the next data byte lands in (lanes 0..2 are buffered).
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        assign lane_sel[gi] = (byte_cnt_q == 2'(gi));
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_buf_d  = word_buf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d      = {in_data, len_q[7:0]};
                    word_cnt_d = 16'd0;
                    byte_cnt_d = 2'd0;
                    if (len_d == 16'd0) begin
                        state_d = DATA_EXIT;
                    end else if ({1'b0, len_d} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    for (int i = 0; i < 3; i++) begin
                        if (lane_sel[i]) begin
                            word_buf_d[8*i +: 8] = in_data;
                        end
                    end
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = {in_data, word_buf_q};
                        word_cnt_d  = word_cnt_q + 16'd1;
                        if (word_cnt_q == len_q - 16'd1) begin
                            state_d = DATA_EXIT;
                        end
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DRAIN : S_ERROR;
                end
            end
`endif
            S_DRAIN: begin
                // Gives the final write its cycle before the processor is released.
                state_d = S_DONE;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // in_ready reflects the state being entered so it is already low in DRAIN.
        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                     || (state_d == S_CSUM)
`endif
                     ;
        cpu_rst_d = (state_q != S_DONE);
        done_d    = (state_q == S_DONE);
        err_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN_LO;
            len_q       <= 16'd0;
            word_cnt_q  <= 16'd0;
            byte_cnt_q  <= 2'd0;
            word_buf_q  <= 24'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_buf_q  <= word_buf_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a scoreboard of expected memory writes is filled as
// images are streamed in and compared against writes captured from the DUT.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        in_ready, mem_we, cpu_rst, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        sm_in_ready, sm_mem_we, sm_cpu_rst, sm_done, sm_err;
    logic [1:0]  sm_mem_addr;
    logic [31:0] sm_mem_wdata;

    prog_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    // Small-memory instance sharing the same stream, used for the capacity boundary.
    prog_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(sm_in_ready), .mem_we(sm_mem_we), .mem_addr(sm_mem_addr),
        .mem_wdata(sm_mem_wdata), .cpu_rst(sm_cpu_rst), .done(sm_done), .err(sm_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] obs_addr[64];
    logic [31:0] obs_data[64];
    int          obs_n = 0;
    int          rd_idx = 0;
    int          sm_we_n = 0;
    logic [7:0]  stim_q[$];
    logic [31:0] img_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1 && obs_n < 64) begin
            obs_addr[obs_n] = 32'(mem_addr);
            obs_data[obs_n] = mem_wdata;
            obs_n++;
        end
        if (sm_mem_we === 1'b1) sm_we_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_sm_err", 32'(sm_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_bytes(input bit toggle);
        int stalls;
        bit acc;
        stalls = 0;
        foreach (stim_q[i]) begin
            if (toggle && i > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_data  = stim_q[i];
            in_valid = 1'b1;
            acc = 1'b0;
            for (int w = 0; w < 40 && !acc; w++) begin
                @(negedge clk);
                acc = (in_ready === 1'b1);
                if (!acc && i > 0) stalls++;
                @(posedge clk); #1;
            end
            if (!acc) begin
                check("accept_timeout", 32'(acc), 1);
                in_valid = 1'b0;
                return;
            end
            $display("byte %0d = 0x%02h accepted at %0t", i, stim_q[i], $time);
        end
        in_valid = 1'b0;
        if (!toggle) check("no_bubbles", 32'(stalls), 0);
    endtask

    // Called right after the edge that accepted the last byte.
    task automatic check_release(input string tag);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_cpu_rst_t0"}, 32'(cpu_rst), 1);
        check({tag, "_done_t0"}, 32'(done), 0);
        @(negedge clk);
        check({tag, "_cpu_rst_t1"}, 32'(cpu_rst), 1);
        @(negedge clk);
        check({tag, "_cpu_rst_t2"}, 32'(cpu_rst), 0);
        check({tag, "_done_t2"}, 32'(done), 1);
        check({tag, "_err"}, 32'(err), 0);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({tag, "_done_ready"}, 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n_extra;
        n_extra = 0;
        while (rd_idx < obs_n) begin
            if (exp_addr_q.size() == 0) begin
                n_extra++;
            end else begin
                check({tag, "_addr"}, obs_addr[rd_idx], exp_addr_q.pop_front());
                check({tag, "_data"}, obs_data[rd_idx], exp_data_q.pop_front());
            end
            $display("write %0d: addr %0d data 0x%08h", rd_idx, obs_addr[rd_idx], obs_data[rd_idx]);
            rd_idx++;
        end
        check({tag, "_extra_writes"}, 32'(n_extra), 0);
        check({tag, "_missing_writes"}, 32'(exp_addr_q.size()), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic load_image(input bit toggle, input string tag);
        logic [15:0] n;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        n = 16'(img_q.size());
        stim_q.delete();
        stim_q.push_back(n[7:0]);
        stim_q.push_back(n[15:8]);
        foreach (img_q[i]) begin
            for (int k = 0; k < 4; k++) begin
                stim_q.push_back(img_q[i][8*k +: 8]);
`ifdef PROG_LOADER_CHECKSUM_EN
                cs ^= img_q[i][8*k +: 8];
`endif
            end
            exp_addr_q.push_back(32'(i));
            exp_data_q.push_back(img_q[i]);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        stim_q.push_back(cs);
`endif
        send_bytes(toggle);
        check_release(tag);
        check_writes(tag);
    endtask

    initial begin
        int sm_snap;

        // Image of two words with valid held high.
        do_reset();
        img_q = '{32'h0000_0013, 32'h0010_0093};
        load_image(1'b0, "basic");

        // Same image with valid toggling.
        do_reset();
        img_q = '{32'h0000_0013, 32'h0010_0093};
        load_image(1'b1, "toggle");

        // Empty image.
        do_reset();
        img_q.delete();
        load_image(1'b0, "empty");

        // Larger random image.
        do_reset();
        img_q.delete();
        for (int i = 0; i < 5; i++) img_q.push_back($urandom);
        load_image(1'b0, "random");

        // Reset in the middle of a load; partial word must never be written.
        do_reset();
        stim_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(32'h4433_2211);
        send_bytes(1'b0);
        @(negedge clk);
        check_writes("partial_pre");
        do_reset();
        img_q = '{32'hDDCC_BBAA};
        load_image(1'b0, "after_abort");

        // Oversized image for a 4-word memory.
        do_reset();
        sm_snap = sm_we_n;
        stim_q = '{8'h05, 8'h00};
        send_bytes(1'b0);
        @(negedge clk);
        check("ovf_sm_err", 32'(sm_err), 1);
        check("ovf_sm_cpu_rst", 32'(sm_cpu_rst), 1);
        check("ovf_sm_in_ready", 32'(sm_in_ready), 0);
        check("ovf_big_err", 32'(err), 0);
        check("ovf_big_in_ready", 32'(in_ready), 1);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ovf_sm_stuck_err", 32'(sm_err), 1);
            check("ovf_sm_stuck_ready", 32'(sm_in_ready), 0);
        end
        in_valid = 1'b0;
        check("ovf_sm_no_write", 32'(sm_we_n - sm_snap), 0);

        // Exactly full small memory is legal.
        do_reset();
        stim_q = '{8'h04, 8'h00};
        send_bytes(1'b0);
        @(negedge clk);
        check("full_sm_err", 32'(sm_err), 0);
        check("full_sm_in_ready", 32'(sm_in_ready), 1);
        do_reset();
        rd_idx = obs_n;

`ifdef PROG_LOADER_CHECKSUM_EN
        // Explicit checksum match and mismatch.
        do_reset();
        stim_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(32'h0403_0201);
        send_bytes(1'b0);
        check_release("csum_ok");
        check_writes("csum_ok");

        do_reset();
        stim_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_addr_q.push_back(32'd0);
        exp_data_q.push_back(32'h0403_0201);
        send_bytes(1'b0);
        for (int c = 0; c < 3; c++) @(negedge clk);
        check("csum_bad_err", 32'(err), 1);
        check("csum_bad_cpu_rst", 32'(cpu_rst), 1);
        check("csum_bad_done", 32'(done), 0);
        check("csum_bad_in_ready", 32'(in_ready), 0);
        check_writes("csum_bad");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
